// File: rtl/seq_divider_16x8_if.sv
// rtl/seq_divider_16x8_if.sv - valid/ready operand and result bundle for the 16/8 divider
interface seq_divider_16x8_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16x8.sv
// rtl/seq_divider_16x8.sv - sequential radix-2 restoring divider, 16-bit dividend by 8-bit divisor
module seq_divider_16x8 (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_16x8_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_q;      // dividend shifts out of the top, quotient bits enter at the bottom
  logic [7:0]  r_rem;    // partial remainder; always < divisor between steps
  logic [7:0]  r_div;
  logic [4:0]  r_cnt;
  logic        r_dbz;

  // The trial is 9 bits wide so the shifted-in remainder never overflows the compare.
  logic [8:0]  w_trial;
  logic        w_ge;
  logic [7:0]  w_rem_next;

  assign w_trial    = {r_rem, r_q[15]};
  assign w_ge       = w_trial[8] | (w_trial[7:0] >= r_div);
  // When w_ge holds the true difference is below the divisor, so 8-bit wraparound is exact.
  assign w_rem_next = w_ge ? (w_trial[7:0] - r_div) : w_trial[7:0];

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.quotient    = r_q;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

  // Next-state decode: accept in IDLE, step in CALC until the last count, hand off in DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_next = (bus.divisor == 8'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (r_cnt == 5'd1) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: load operands on acceptance, one restoring step per CALC cycle, hold in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= 16'd0;
      r_rem <= 8'd0;
      r_div <= 8'd0;
      r_cnt <= 5'd0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_div <= bus.divisor;
            r_cnt <= 5'd16;
            if (bus.divisor == 8'd0) begin
              r_q   <= 16'hFFFF;
              r_rem <= bus.dividend[7:0];
              r_dbz <= 1'b1;
            end else begin
              r_q   <= bus.dividend;
              r_rem <= 8'd0;
              r_dbz <= 1'b0;
            end
          end
        end
        CALC: begin
          r_q   <= {r_q[14:0], w_ge};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 5'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
